// File: rtl/dvp_line_split_pkg.sv
// ============================================================================
// Module      : dvp_pkg
// Description : Shared defaults, FSM state encoding and line-geometry helpers
//               for the DVP line splitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dvp_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 12;
    localparam int H_HALF_DEF = 640;
    localparam int V_MAX_DEF  = 1023;
    localparam int OFFSET_DEF = 100;

    localparam int LINE_LEN      = 2 * H_HALF_DEF;
    localparam int SPLIT_LEFT_LO = 0;
    localparam int SPLIT_RIGHT_LO = H_HALF_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        DROP  = 2'b11
    } state_t;

    function automatic int line_len(input int h_half);
        return 2 * h_half;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dvp_line_split_if.sv
// ============================================================================
// Module      : dvp_line_split_if
// Description : Merged DVP input stream plus split per-camera output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dvp_line_split_if #(
    parameter int DATA_W = dvp_pkg::DATA_W_DEF,
    parameter int CNT_W  = dvp_pkg::CNT_W_DEF
);
    logic              pixel_vsync;
    logic              pixel_href;
    logic [DATA_W-1:0] pixel_data;

    logic              cam1_valid;
    logic [DATA_W-1:0] cam1_data;
    logic              cam0_valid;
    logic [DATA_W-1:0] cam0_data;
    logic              sol;
    logic              eol;
    logic              sof;
    logic [CNT_W-1:0]  line_cnt;
    logic              err_short;
    logic              err_long;

    modport master (
        output pixel_vsync, pixel_href, pixel_data,
        input  cam1_valid, cam1_data, cam0_valid, cam0_data,
        input  sol, eol, sof, line_cnt, err_short, err_long
    );

    modport slave (
        input  pixel_vsync, pixel_href, pixel_data,
        output cam1_valid, cam1_data, cam0_valid, cam0_data,
        output sol, eol, sof, line_cnt, err_short, err_long
    );
endinterface

`default_nettype wire

// File: rtl/dvp_line_split_edge_det.sv
// ============================================================================
// Module      : dvp_edge_det
// Description : Registers a level once and reports its rising or falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvp_edge_det #(
    parameter bit FALLING = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic sig,
    output logic      level,
    output logic      pulse
);

    logic r_d;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d    <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_d    <= sig;
            r_prev <= r_d;
        end
    end

    assign level = r_d;

    generate
        if (FALLING) begin : g_fall
            assign pulse = ~r_d & r_prev;
        end else begin : g_rise
            assign pulse = r_d & ~r_prev;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/dvp_line_split.sv
// ============================================================================
// Module      : dvp_line_split
// Description : Splits merged cam1|cam0 DVP lines into two per-camera streams
//               and checks line geometry. Optional macro: DVP_SPLIT_OFFSET_EN
//               skips OFFSET leading pixels per line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvp_line_split
    import dvp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int H_HALF = H_HALF_DEF,
    parameter int V_MAX  = V_MAX_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int OFFSET = OFFSET_DEF
) (
    input wire logic         pixel_pclk,
    input wire logic         sys_rst_n,
    dvp_line_split_if.slave  bus
);

`ifdef DVP_SPLIT_OFFSET_EN
    localparam int c_OFF = OFFSET;
`else
    // Offset has no effect in this build.
    localparam int c_OFF = 0 * OFFSET;
`endif

    localparam int c_LEFT_LO   = c_OFF;
    localparam int c_LEFT_EOL  = c_OFF + H_HALF - 1;
    localparam int c_RIGHT_LO  = c_OFF + H_HALF;
    localparam int c_LINE_END  = c_OFF + line_len(H_HALF);
    localparam int c_RIGHT_EOL = c_LINE_END - 1;
    localparam logic [CNT_W-1:0] c_V_MAX = CNT_W'(V_MAX);

    logic              w_vsync_d;
    logic              w_vs_rise;
    logic              w_href_d;
    logic              w_href_fall;
    logic [DATA_W-1:0] r_data_d;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_col;
    logic [CNT_W-1:0]  w_col_nxt;
    logic [CNT_W-1:0]  w_pix_col;
    int                w_pix;

    logic w_c1_v, w_c0_v, w_sol, w_eol;
    logic w_set_long, w_set_short, w_line_end;

    logic              r_cam1_valid, r_cam0_valid, r_sol, r_eol, r_sof;
    logic [DATA_W-1:0] r_cam1_data, r_cam0_data;
    logic [CNT_W-1:0]  r_line_cnt;
    logic              r_err_short, r_err_long;

    dvp_edge_det #(.FALLING(1'b0)) u_vsync_det (
        .clk   (pixel_pclk),
        .rst_n (sys_rst_n),
        .sig   (bus.pixel_vsync),
        .level (w_vsync_d),
        .pulse (w_vs_rise)
    );

    dvp_edge_det #(.FALLING(1'b1)) u_href_det (
        .clk   (pixel_pclk),
        .rst_n (sys_rst_n),
        .sig   (bus.pixel_href),
        .level (w_href_d),
        .pulse (w_href_fall)
    );

    always_ff @(posedge pixel_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_data_d <= '0;
            r_state  <= IDLE;
            r_col    <= '0;
        end else begin
            r_data_d <= bus.pixel_data;
            r_state  <= w_state_nxt;
            r_col    <= w_col_nxt;
        end
    end

    // The first pixel of a line is handled in the IDLE cycle itself at column 0.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_pix_col   = (r_state == IDLE) ? '0 : r_col;
        w_pix       = int'(w_pix_col);
        w_c1_v      = 1'b0;
        w_c0_v      = 1'b0;
        w_sol       = 1'b0;
        w_eol       = 1'b0;
        w_set_long  = 1'b0;
        w_set_short = 1'b0;
        w_line_end  = 1'b0;

        if (w_href_d) begin
            w_col_nxt = (w_pix_col == '1) ? w_pix_col : w_pix_col + 1'b1;
            if (w_pix >= c_LINE_END) begin
                w_set_long  = 1'b1;
                w_state_nxt = DROP;
            end else if (w_pix >= c_RIGHT_LO) begin
                w_c0_v      = 1'b1;
                w_sol       = (w_pix == c_RIGHT_LO);
                w_eol       = (w_pix == c_RIGHT_EOL);
                w_state_nxt = (w_pix == c_RIGHT_EOL) ? DROP : RIGHT;
            end else if (w_pix >= c_LEFT_LO) begin
                w_c1_v      = 1'b1;
                w_sol       = (w_pix == c_LEFT_LO);
                w_eol       = (w_pix == c_LEFT_EOL);
                w_state_nxt = (w_pix == c_LEFT_EOL) ? RIGHT : LEFT;
            end else begin
                w_state_nxt = LEFT;
            end
        end else if (w_href_fall && (r_state != IDLE)) begin
            w_line_end  = 1'b1;
            w_set_short = (int'(r_col) < c_LINE_END);
            w_state_nxt = IDLE;
            w_col_nxt   = '0;
        end

        if (w_vs_rise) begin
            w_state_nxt = IDLE;
            w_col_nxt   = '0;
        end
    end

    always_ff @(posedge pixel_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cam1_valid <= 1'b0;
            r_cam0_valid <= 1'b0;
            r_cam1_data  <= '0;
            r_cam0_data  <= '0;
            r_sol        <= 1'b0;
            r_eol        <= 1'b0;
            r_sof        <= 1'b0;
            r_line_cnt   <= '0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
        end else begin
            r_cam1_valid <= w_c1_v;
            r_cam0_valid <= w_c0_v;
            r_sol        <= w_sol;
            r_eol        <= w_eol;
            r_sof        <= w_vs_rise & w_vsync_d;
            if (w_c1_v) r_cam1_data <= r_data_d;
            if (w_c0_v) r_cam0_data <= r_data_d;

            // Frame start wins over any line-end bookkeeping in the same cycle.
            if (w_vs_rise) begin
                r_line_cnt  <= '0;
                r_err_short <= 1'b0;
                r_err_long  <= 1'b0;
            end else begin
                if (w_line_end && (r_line_cnt != c_V_MAX))
                    r_line_cnt <= r_line_cnt + 1'b1;
                if (w_set_short) r_err_short <= 1'b1;
                if (w_set_long)  r_err_long  <= 1'b1;
            end
        end
    end

    assign bus.cam1_valid = r_cam1_valid;
    assign bus.cam1_data  = r_cam1_data;
    assign bus.cam0_valid = r_cam0_valid;
    assign bus.cam0_data  = r_cam0_data;
    assign bus.sol        = r_sol;
    assign bus.eol        = r_eol;
    assign bus.sof        = r_sof;
    assign bus.line_cnt   = r_line_cnt;
    assign bus.err_short  = r_err_short;
    assign bus.err_long   = r_err_long;

endmodule

`default_nettype wire

// File: tb/tb_dvp_line_split.sv
// ============================================================================
// Module      : tb_dvp_line_split
// Description : Directed self-checking bench for dvp_line_split (honours
//               DVP_SPLIT_OFFSET_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dvp_line_split;

`ifdef DVP_SPLIT_OFFSET_EN
    localparam int OFF = 100;
`else
    localparam int OFF = 0;
`endif
    localparam int H    = 640;
    localparam int FULL = 2 * H + OFF;

    logic clk;
    logic rst_n;

    dvp_line_split_if #(.DATA_W(16), .CNT_W(12)) bus ();

    dvp_line_split dut (
        .pixel_pclk (clk),
        .sys_rst_n  (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0     = 0;
    logic clr  = 1'b0;

    // Monitor statistics, sampled on the falling edge
    int n1, n0, first1, last1, first0, last0, seq1, seq0;
    int sol1, eol1, sol0, eol0, nsol1, neol1, nsol0, neol0;
    int both, stray, nsof, tfirst;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (clr) begin
            n1 = 0; n0 = 0; first1 = -1; last1 = -1; first0 = -1; last0 = -1;
            seq1 = 0; seq0 = 0; sol1 = -1; eol1 = -1; sol0 = -1; eol0 = -1;
            nsol1 = 0; neol1 = 0; nsol0 = 0; neol0 = 0;
            both = 0; stray = 0; nsof = 0; tfirst = -1;
        end else begin
            if (bus.sof) nsof = nsof + 1;
            if ((bus.cam1_valid || bus.cam0_valid) && tfirst < 0) tfirst = cyc;
            if (bus.cam1_valid && bus.cam0_valid) both = both + 1;
            if ((bus.sol || bus.eol) && !bus.cam1_valid && !bus.cam0_valid) stray = stray + 1;
            if (bus.cam1_valid) begin
                if (n1 == 0) first1 = int'(bus.cam1_data);
                else if (int'(bus.cam1_data) != last1 + 1) seq1 = seq1 + 1;
                last1 = int'(bus.cam1_data);
                n1 = n1 + 1;
                if (bus.sol) begin sol1 = int'(bus.cam1_data); nsol1 = nsol1 + 1; end
                if (bus.eol) begin eol1 = int'(bus.cam1_data); neol1 = neol1 + 1; end
            end
            if (bus.cam0_valid) begin
                if (n0 == 0) first0 = int'(bus.cam0_data);
                else if (int'(bus.cam0_data) != last0 + 1) seq0 = seq0 + 1;
                last0 = int'(bus.cam0_data);
                n0 = n0 + 1;
                if (bus.sol) begin sol0 = int'(bus.cam0_data); nsol0 = nsol0 + 1; end
                if (bus.eol) begin eol0 = int'(bus.cam0_data); neol0 = neol0 + 1; end
            end
        end
    end

    task automatic clear_stats();
        @(negedge clk); #1; clr = 1'b1;
        @(negedge clk); #1; clr = 1'b0;
    endtask

    task automatic send_line(input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk); #1;
            bus.pixel_href = 1'b1;
            bus.pixel_data = 16'(i);
            if (i == 0) t0 = cyc;
        end
        @(negedge clk); #1;
        bus.pixel_href = 1'b0;
        bus.pixel_data = 16'h0;
        repeat (4) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        @(negedge clk); #1; bus.pixel_vsync = 1'b1;
        repeat (3) @(negedge clk);
        #1; bus.pixel_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.cam1_valid !== 1'b0 || bus.cam0_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b%b required 00", bus.cam1_valid, bus.cam0_valid); end
        checks++; if (bus.sol !== 1'b0 || bus.eol !== 1'b0 || bus.sof !== 1'b0) begin errors++;
            $display("FAIL reset_markers: got sol=%b eol=%b sof=%b required 0", bus.sol, bus.eol, bus.sof); end
        checks++; if (bus.line_cnt !== 12'd0) begin errors++;
            $display("FAIL reset_line_cnt: got %0d required 0", bus.line_cnt); end
        checks++; if (bus.err_short !== 1'b0 || bus.err_long !== 1'b0) begin errors++;
            $display("FAIL reset_err: got short=%b long=%b required 0", bus.err_short, bus.err_long); end
        checks++; if (bus.cam1_data !== 16'd0 || bus.cam0_data !== 16'd0) begin errors++;
            $display("FAIL reset_data: got %0d/%0d required 0/0", bus.cam1_data, bus.cam0_data); end
    endtask

    task automatic test_full_line();
        clear_stats();
        send_line(FULL);
        checks++; if (tfirst - t0 != 2 + OFF) begin errors++;
            $display("FAIL full_latency: got %0d required %0d", tfirst - t0, 2 + OFF); end
        checks++; if (n1 != H || first1 != OFF || seq1 != 0) begin errors++;
            $display("FAIL full_cam1: got n=%0d first=%0d seq=%0d required n=%0d first=%0d seq=0", n1, first1, seq1, H, OFF); end
        checks++; if (sol1 != OFF || eol1 != OFF + H - 1 || nsol1 != 1 || neol1 != 1) begin errors++;
            $display("FAIL full_cam1_marks: got sol=%0d eol=%0d required sol=%0d eol=%0d", sol1, eol1, OFF, OFF + H - 1); end
        checks++; if (n0 != H || first0 != OFF + H || seq0 != 0) begin errors++;
            $display("FAIL full_cam0: got n=%0d first=%0d seq=%0d required n=%0d first=%0d seq=0", n0, first0, seq0, H, OFF + H); end
        checks++; if (sol0 != OFF + H || eol0 != FULL - 1 || nsol0 != 1 || neol0 != 1) begin errors++;
            $display("FAIL full_cam0_marks: got sol=%0d eol=%0d required sol=%0d eol=%0d", sol0, eol0, OFF + H, FULL - 1); end
        checks++; if (both != 0 || stray != 0) begin errors++;
            $display("FAIL full_exclusive: got both=%0d stray=%0d required 0/0", both, stray); end
        checks++; if (bus.cam1_data !== 16'(OFF + H - 1) || bus.cam0_data !== 16'(FULL - 1)) begin errors++;
            $display("FAIL full_hold: got %0d/%0d required %0d/%0d", bus.cam1_data, bus.cam0_data, OFF + H - 1, FULL - 1); end
        checks++; if (bus.line_cnt !== 12'd1) begin errors++;
            $display("FAIL full_line_cnt: got %0d required 1", bus.line_cnt); end
        checks++; if (bus.err_short !== 1'b0 || bus.err_long !== 1'b0) begin errors++;
            $display("FAIL full_err: got short=%b long=%b required 0/0", bus.err_short, bus.err_long); end
    endtask

    task automatic test_short_line();
        clear_stats();
        send_line(FULL - 5);
        checks++; if (n0 != H - 5 || neol0 != 0 || n1 != H) begin errors++;
            $display("FAIL short_counts: got n1=%0d n0=%0d eol0=%0d required %0d/%0d/0", n1, n0, neol0, H, H - 5); end
        checks++; if (bus.err_short !== 1'b1 || bus.err_long !== 1'b0) begin errors++;
            $display("FAIL short_err: got short=%b long=%b required 1/0", bus.err_short, bus.err_long); end
        checks++; if (bus.line_cnt !== 12'd2) begin errors++;
            $display("FAIL short_line_cnt: got %0d required 2", bus.line_cnt); end
    endtask

    task automatic test_sof();
        clear_stats();
        vsync_pulse();
        checks++; if (nsof != 1) begin errors++;
            $display("FAIL sof_pulse: got %0d cycles required 1", nsof); end
        checks++; if (bus.err_short !== 1'b0 || bus.line_cnt !== 12'd0) begin errors++;
            $display("FAIL sof_clear: got short=%b cnt=%0d required 0/0", bus.err_short, bus.line_cnt); end
    endtask

    task automatic test_long_line();
        clear_stats();
        send_line(FULL + 10);
        checks++; if (n1 != H || n0 != H || last0 != FULL - 1 || eol0 != FULL - 1) begin errors++;
            $display("FAIL long_counts: got n1=%0d n0=%0d last0=%0d required %0d/%0d/%0d", n1, n0, last0, H, H, FULL - 1); end
        checks++; if (bus.err_long !== 1'b1 || bus.err_short !== 1'b0) begin errors++;
            $display("FAIL long_err: got long=%b short=%b required 1/0", bus.err_long, bus.err_short); end
        checks++; if (bus.line_cnt !== 12'd1) begin errors++;
            $display("FAIL long_line_cnt: got %0d required 1", bus.line_cnt); end
    endtask

    task automatic burst_lines(input int count);
        for (int k = 0; k < count; k++) begin
            @(negedge clk); #1; bus.pixel_href = 1'b1; bus.pixel_data = 16'h0;
            @(negedge clk); #1; bus.pixel_data = 16'h1;
            @(negedge clk); #1; bus.pixel_href = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_saturate();
        vsync_pulse();
        burst_lines(1022);
        checks++; if (bus.line_cnt !== 12'd1022) begin errors++;
            $display("FAIL sat_below: got %0d required 1022", bus.line_cnt); end
        burst_lines(78);
        checks++; if (bus.line_cnt !== 12'd1023) begin errors++;
            $display("FAIL sat_cap: got %0d required 1023", bus.line_cnt); end
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < OFF + 300; i++) begin
            @(negedge clk); #1; bus.pixel_href = 1'b1; bus.pixel_data = 16'(i);
        end
        @(negedge clk); #1; rst_n = 1'b0; bus.pixel_href = 1'b0;
        @(negedge clk);
        checks++; if (bus.cam1_valid !== 1'b0 || bus.line_cnt !== 12'd0 || bus.err_short !== 1'b0) begin errors++;
            $display("FAIL rst_mid_clear: got v=%b cnt=%0d short=%b required 0/0/0", bus.cam1_valid, bus.line_cnt, bus.err_short); end
        #1; rst_n = 1'b1;
        clear_stats();
        repeat (5) @(negedge clk);
        checks++; if (n1 + n0 != 0 || neol1 + neol0 != 0) begin errors++;
            $display("FAIL rst_mid_stray: got valids=%0d eols=%0d required 0/0", n1 + n0, neol1 + neol0); end
        clear_stats();
        send_line(FULL);
        checks++; if (n1 != H || first1 != OFF || sol1 != OFF || n0 != H || eol0 != FULL - 1) begin errors++;
            $display("FAIL rst_mid_line: got n1=%0d first1=%0d n0=%0d eol0=%0d required %0d/%0d/%0d/%0d", n1, first1, n0, eol0, H, OFF, H, FULL - 1); end
        checks++; if (bus.line_cnt !== 12'd1 || bus.err_short !== 1'b0) begin errors++;
            $display("FAIL rst_mid_cnt: got cnt=%0d short=%b required 1/0", bus.line_cnt, bus.err_short); end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.pixel_vsync = 1'b0;
        bus.pixel_href  = 1'b0;
        bus.pixel_data  = 16'h0;
        repeat (3) @(negedge clk);
        test_reset();
        #1; rst_n = 1'b1;
        test_full_line();
        test_short_line();
        test_sof();
        test_long_line();
        test_saturate();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
